ppu_scroll: RTL and testbench

//  PPU scroll/VRAM-address unit (loopy v/t/x/w). Sits upstream of render.
//  - Decodes CPU writes to $2000/$2005/$2006, $2002 reads and $2007 accesses.
//  - Applies render's v_incx/v_incy/v_resetx/v_resety strobes to v.
//  - Supplies render with fine_x, fine_y and the attribute pair attr_o.
//  - Muxes the 14-bit VRAM address for NT/AT/CHR fetches and CPU access.

---
 rtl/ppu_pkg.sv | 57 +++++
 rtl/ppu_vram_addr_mux.sv | 41 ++++
 rtl/ppu_scroll.sv | 129 ++++++++++++
 tb/tb_ppu_scroll.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU constants: register indices, PPUCTRL bits, loopy v/t field positions
// and the render-time scroll increment helpers.
package ppu_pkg;

  localparam logic [2:0] PPUCTRL   = 3'd0;
  localparam logic [2:0] PPUMASK   = 3'd1;
  localparam logic [2:0] PPUSTATUS = 3'd2;
  localparam logic [2:0] OAMADDR   = 3'd3;
  localparam logic [2:0] OAMDATA   = 3'd4;
  localparam logic [2:0] PPUSCROLL = 3'd5;
  localparam logic [2:0] PPUADDR   = 3'd6;
  localparam logic [2:0] PPUDATA   = 3'd7;

  localparam int CTRL_NT_LO = 0;
  localparam int CTRL_NT_HI = 1;
  localparam int CTRL_INC   = 2;

  // LSB positions of the v/t fields
  localparam int COARSE_X = 0;
  localparam int COARSE_Y = 5;
  localparam int NT_X     = 10;
  localparam int NT_Y     = 11;
  localparam int FINE_Y   = 12;

  function automatic logic [14:0] inc_coarse_x(input logic [14:0] v);
    logic [14:0] r;
    r = v;
    if (v[COARSE_X +: 5] == 5'd31) begin
      r[COARSE_X +: 5] = 5'd0;
      r[NT_X]          = ~v[NT_X];
    end else begin
      r[COARSE_X +: 5] = v[COARSE_X +: 5] + 5'd1;
    end
    return r;
  endfunction

  // Coarse Y 30/31 live in attribute space; 31 wraps without switching nametable.
  function automatic logic [14:0] inc_y(input logic [14:0] v);
    logic [14:0] r;
    r = v;
    if (v[FINE_Y +: 3] != 3'd7) begin
      r[FINE_Y +: 3] = v[FINE_Y +: 3] + 3'd1;
    end else begin
      r[FINE_Y +: 3] = 3'd0;
      if (v[COARSE_Y +: 5] == 5'd29) begin
        r[COARSE_Y +: 5] = 5'd0;
        r[NT_Y]          = ~v[NT_Y];
      end else if (v[COARSE_Y +: 5] == 5'd31) begin
        r[COARSE_Y +: 5] = 5'd0;
      end else begin
        r[COARSE_Y +: 5] = v[COARSE_Y +: 5] + 5'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ppu_vram_addr_mux.sv
// VRAM address select for NT/AT/CHR fetches and CPU access, plus the
// attribute-pair latch feeding render.
module ppu_vram_addr_mux
  import ppu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_tile,
  input  logic        fetch_attr,
  input  logic        fetch_chr,
  input  logic [12:0] pattern_idx,
  input  logic [13:0] v,
  input  logic [7:0]  data_i,
  output logic [13:0] vram_addr,
  output logic [1:0]  attr_o
);

  logic [1:0] attr_sel;

  always_comb begin
    vram_addr = v;
    if (fetch_tile)
      vram_addr = {2'b10, v[11:0]};
    else if (fetch_attr)
      vram_addr = {2'b10, v[11:10], 4'b1111, v[9:7], v[4:2]};
    else if (fetch_chr)
      vram_addr = {1'b0, pattern_idx};
  end

  // Quadrant within the 32x32 attribute cell: {coarse_y[1], coarse_x[1]}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          attr_sel <= 2'd0;
    else if (fetch_attr) attr_sel <= {v[6], v[1]};
  end

  assign attr_o = data_i[{attr_sel, 1'b0} +: 2];

  a_fetch_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({fetch_tile, fetch_attr, fetch_chr}));

endmodule

// File: rtl/ppu_scroll.sv
// Loopy v/t/x/w scroll registers: CPU register decode, render-driven
// increments/copies, and the VRAM address mux.
module ppu_scroll
  import ppu_pkg::*;
#(
  parameter int RENDER_GLITCH_INC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  cpu_addr,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [7:0]  cpu_din,
  input  logic        rendering,
  input  logic        v_incx,
  input  logic        v_incy,
  input  logic        v_resetx,
  input  logic        v_resety,
  input  logic        fetch_tile,
  input  logic        fetch_attr,
  input  logic        fetch_chr,
  input  logic [12:0] pattern_idx,
  input  logic [7:0]  data_i,
  output logic [2:0]  fine_x,
  output logic [2:0]  fine_y,
  output logic [1:0]  attr_o,
  output logic [13:0] vram_addr,
  output logic [14:0] v_o
);

  logic [14:0] v, t, v_n, t_n;
  logic [2:0]  x, x_n;
  logic        w, w_n, ctrl_inc, load_v;
  logic        data_acc, any_strobe, do_x, do_y;

  assign data_acc   = (cpu_wr || cpu_rd) && (cpu_addr == PPUDATA);
  assign any_strobe = v_incx || v_incy || v_resetx || v_resety;

  always_comb begin
    t_n    = t;
    x_n    = x;
    w_n    = w;
    load_v = 1'b0;
    if (cpu_wr) begin
      case (cpu_addr)
        PPUCTRL: t_n[NT_X +: 2] = cpu_din[CTRL_NT_HI:CTRL_NT_LO];
        PPUSCROLL: begin
          if (!w) begin
            t_n[COARSE_X +: 5] = cpu_din[7:3];
            x_n                = cpu_din[2:0];
          end else begin
            t_n[FINE_Y +: 3]   = cpu_din[2:0];
            t_n[COARSE_Y +: 5] = cpu_din[7:3];
          end
          w_n = ~w;
        end
        PPUADDR: begin
          if (!w) begin
            t_n[14]   = 1'b0;
            t_n[13:8] = cpu_din[5:0];
          end else begin
            t_n[7:0] = cpu_din;
            load_v   = 1'b1;
          end
          w_n = ~w;
        end
        default: ;
      endcase
    end
    if (cpu_rd && cpu_addr == PPUSTATUS) w_n = 1'b0;
  end

  // Apply lowest priority first so later assignments override.
  always_comb begin
    v_n  = v;
    do_x = v_incx;
    do_y = v_incy;
    if (data_acc && !any_strobe) begin
      if (rendering && RENDER_GLITCH_INC != 0) {do_x, do_y} = 2'b11;
      else v_n = v + (ctrl_inc ? 15'd32 : 15'd1);
    end
    if (do_x) v_n = inc_coarse_x(v_n);
    if (do_y) v_n = inc_y(v_n);
    if (v_resetx) begin
      v_n[NT_X]          = t[NT_X];
      v_n[COARSE_X +: 5] = t[COARSE_X +: 5];
    end
    if (v_resety) begin
      v_n[FINE_Y +: 3]   = t[FINE_Y +: 3];
      v_n[NT_Y]          = t[NT_Y];
      v_n[COARSE_Y +: 5] = t[COARSE_Y +: 5];
    end
    if (load_v) v_n = t_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v        <= '0;
      t        <= '0;
      x        <= '0;
      w        <= 1'b0;
      ctrl_inc <= 1'b0;
    end else begin
      v <= v_n;
      t <= t_n;
      x <= x_n;
      w <= w_n;
      if (cpu_wr && cpu_addr == PPUCTRL) ctrl_inc <= cpu_din[CTRL_INC];
    end
  end

  assign fine_x = x;
  assign fine_y = v[FINE_Y +: 3];
  assign v_o    = v;

  ppu_vram_addr_mux u_mux (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_tile (fetch_tile),
    .fetch_attr (fetch_attr),
    .fetch_chr  (fetch_chr),
    .pattern_idx(pattern_idx),
    .v          (v[13:0]),
    .data_i     (data_i),
    .vram_addr  (vram_addr),
    .attr_o     (attr_o)
  );

endmodule

// File: tb/tb_ppu_scroll.sv
// Directed bench for ppu_scroll: hand-computed v/t/x results for register
// writes, render strobes, priorities, attribute fetch and reset behaviour.
module tb_ppu_scroll;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  cpu_addr = '0;
  logic        cpu_wr = 1'b0, cpu_rd = 1'b0;
  logic [7:0]  cpu_din = '0;
  logic        rendering = 1'b0;
  logic        v_incx = 1'b0, v_incy = 1'b0, v_resetx = 1'b0, v_resety = 1'b0;
  logic        fetch_tile = 1'b0, fetch_attr = 1'b0, fetch_chr = 1'b0;
  logic [12:0] pattern_idx = '0;
  logic [7:0]  data_i = 8'h1B;
  logic [2:0]  fine_x, fine_y;
  logic [1:0]  attr_o;
  logic [13:0] vram_addr;
  logic [14:0] v_o;

  int nchk = 0;
  int nerr = 0;

  ppu_scroll #(.RENDER_GLITCH_INC(1)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .cpu_din(cpu_din), .rendering(rendering), .v_incx(v_incx), .v_incy(v_incy),
    .v_resetx(v_resetx), .v_resety(v_resety), .fetch_tile(fetch_tile),
    .fetch_attr(fetch_attr), .fetch_chr(fetch_chr), .pattern_idx(pattern_idx),
    .data_i(data_i), .fine_x(fine_x), .fine_y(fine_y), .attr_o(attr_o),
    .vram_addr(vram_addr), .v_o(v_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_din = d; cpu_wr = 1'b1;
    tick();
    cpu_wr = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a);
    cpu_addr = a; cpu_rd = 1'b1;
    tick();
    cpu_rd = 1'b0;
  endtask

  task automatic strobe(input logic rx, input logic ry, input logic ix, input logic iy);
    v_resetx = rx; v_resety = ry; v_incx = ix; v_incy = iy;
    tick();
    {v_resetx, v_resety, v_incx, v_incy} = 4'b0;
  endtask

  // Build t through $2000/$2005 (reaches bit 14) then copy all of t into v.
  task automatic set_v(input logic [14:0] val);
    rd(3'd2);
    wr(3'd0, {6'b0, val[11:10]});
    wr(3'd5, {val[4:0], 3'b000});
    wr(3'd5, {val[9:5], val[14:12]});
    strobe(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #2;
    chk("rst_v", 16'(v_o), 16'h0000);
    chk("rst_fine_x", 16'(fine_x), 16'h0);
    chk("rst_fine_y", 16'(fine_y), 16'h0);
    chk("rst_vram_addr", 16'(vram_addr), 16'h0000);
    chk("rst_attr_o", 16'(attr_o), 16'h3);
    #10 rst_n = 1'b1;
    tick();

    wr(3'd5, 8'h7D);
    chk("scroll1_fine_x", 16'(fine_x), 16'h5);
    wr(3'd5, 8'h5E);
    strobe(1'b1, 1'b1, 1'b0, 1'b0);
    chk("scroll_t", 16'(v_o), 16'h616F);
    chk("scroll_fine_y", 16'(fine_y), 16'h6);
    wr(3'd5, 8'h03);
    chk("w_back_to_first", 16'(fine_x), 16'h3);
    rd(3'd2);

    wr(3'd6, 8'h3F);
    rd(3'd2);
    wr(3'd6, 8'h21);
    chk("addr_v_held", 16'(v_o), 16'h616F);
    wr(3'd6, 8'h08);
    chk("addr_v", 16'(v_o), 16'h2108);
    chk("addr_vram", 16'(vram_addr), 16'h2108);

    set_v(15'h001F); strobe(1'b0, 1'b0, 1'b1, 1'b0);
    chk("incx_wrap", 16'(v_o), 16'h0400);
    set_v(15'h73A0); strobe(1'b0, 1'b0, 1'b0, 1'b1);
    chk("incy_29", 16'(v_o), 16'h0800);
    set_v(15'h73E0); strobe(1'b0, 1'b0, 1'b0, 1'b1);
    chk("incy_31", 16'(v_o), 16'h0000);
    set_v(15'h701F); strobe(1'b0, 1'b0, 1'b1, 1'b1);
    chk("incx_incy", 16'(v_o), 16'h0420);

    set_v(15'h3000);
    wr(3'd0, 8'h01);
    wr(3'd5, 8'hA8);
    wr(3'd5, 8'h00);
    chk("t_not_in_v", 16'(v_o), 16'h3000);
    strobe(1'b1, 1'b0, 1'b1, 1'b0);
    chk("resetx_over_incx", 16'(v_o), 16'h3415);

    wr(3'd6, 8'h12);
    v_incx = 1'b1;
    wr(3'd6, 8'h34);
    v_incx = 1'b0;
    chk("2006_over_incx", 16'(v_o), 16'h1234);
    v_incy = 1'b1;
    wr(3'd7, 8'h00);
    v_incy = 1'b0;
    chk("2007_ignored_strobe", 16'(v_o), 16'h2234);

    wr(3'd6, 8'h28);
    wr(3'd6, 8'h42);
    data_i = 8'hE4;
    fetch_tile = 1'b1; #1;
    chk("tile_addr", 16'(vram_addr), 16'h2842);
    fetch_tile = 1'b0; fetch_chr = 1'b1; pattern_idx = 13'h1ABC; #1;
    chk("chr_addr", 16'(vram_addr), 16'h1ABC);
    fetch_chr = 1'b0; fetch_attr = 1'b1; #1;
    chk("attr_addr", 16'(vram_addr), 16'h2BC0);
    chk("attr_o_pre", 16'(attr_o), 16'h0);
    tick();
    fetch_attr = 1'b0; #1;
    chk("attr_o", 16'(attr_o), 16'h3);

    rendering = 1'b1;
    rd(3'd7);
    rendering = 1'b0;
    chk("glitch_inc", 16'(v_o), 16'h3843);
    wr(3'd7, 8'h00);
    chk("inc1", 16'(v_o), 16'h3844);
    wr(3'd0, 8'h04);
    for (int i = 0; i < 4; i++) wr(3'd7, 8'h00);
    chk("inc32_x4", 16'(v_o), 16'h38C4);
    wr(3'd0, 8'h00);
    wr(3'd6, 8'h3F);
    wr(3'd6, 8'hFF);
    rd(3'd7);
    chk("inc_to_bit14", 16'(v_o), 16'h4000);
    chk("vram_14bit", 16'(vram_addr), 16'h0000);

    wr(3'd5, 8'h07);
    chk("pre_rst_fine_x", 16'(fine_x), 16'h7);
    rst_n = 1'b0;
    #3;
    chk("async_rst_v", 16'(v_o), 16'h0000);
    chk("async_rst_fine_x", 16'(fine_x), 16'h0);
    tick();
    rst_n = 1'b1;
    tick();
    wr(3'd5, 8'h02);
    chk("w_cleared_by_rst", 16'(fine_x), 16'h2);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
